// File: rtl/bnn_pkg.sv
// Shared BNN datapath constants and the popcount/threshold FSM states.
// The PE array uses the same partial-popcount width.
package bnn_pkg;

  localparam int DEF_PSUM_WIDTH = 4;
  localparam int DEF_ACC_WIDTH  = 12;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/sat_accumulate.sv
// Saturating adder: accumulator plus zero-extended partial popcount.
// Clamps to all-ones and raises sat when the true sum does not fit.
module sat_accumulate #(
  parameter int ACC_WIDTH  = 12,
  parameter int PSUM_WIDTH = 4
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [PSUM_WIDTH-1:0] addend,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  sat
);

  logic [ACC_WIDTH:0] wide;

  assign wide = {1'b0, acc}
              + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}}, addend};
  assign sat  = wide[ACC_WIDTH];
  assign sum  = sat ? '1 : wide[ACC_WIDTH-1:0];

endmodule

// File: rtl/xnor_popcount_threshold.sv
// Per-pixel popcount accumulation across channels, folded BN threshold,
// and one binary activation per pixel over a valid/ready handshake.
module xnor_popcount_threshold
  import bnn_pkg::*;
#(
  parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  thr_load,
  input  logic [ACC_WIDTH-1:0]  thr_in,
  input  logic                  thr_invert,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PSUM_WIDTH-1:0] pcount_in,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [ACC_WIDTH-1:0]  out_count,
  output logic                  overflow
);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] thr;
  logic                 inv;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sat;
  logic                 fire;

  assign in_ready = en && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign base     = (state == ACCUM) ? acc : '0;

  sat_accumulate #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_sat (
    .acc    (base),
    .addend (pcount_in),
    .sum    (sum),
    .sat    (sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      thr       <= '0;
      inv       <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      if (thr_load) begin
        thr <= thr_in;
        inv <= thr_invert;
      end
      if (out_ready)
        out_valid <= 1'b0;
      // Compare uses the pre-load threshold; a same-cycle load lands next cycle.
      if (fire) begin
        if (sat)
          overflow <= 1'b1;
        unique case (state)
          IDLE, ACCUM: begin
            if (in_last) begin
              out_count <= sum;
              out_bit   <= (sum >= thr) ^ inv;
              out_valid <= 1'b1;
              acc       <= '0;
              state     <= IDLE;
            end else begin
              acc       <= sum;
              state     <= ACCUM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcount_threshold.sv
// Directed bench for xnor_popcount_threshold: default instance plus a
// narrow-accumulator instance for saturation.
module tb_xnor_popcount_threshold;

  logic        clk = 1'b0;
  logic        rst, en, thr_load, thr_invert;
  logic [11:0] thr_in;
  logic        in_valid, in_ready, in_last;
  logic [3:0]  pcount_in;
  logic        out_valid, out_ready, out_bit, overflow;
  logic [11:0] out_count;

  logic        s_rst, s_en, s_thr_load, s_thr_invert;
  logic [4:0]  s_thr_in;
  logic        s_in_valid, s_in_ready, s_in_last;
  logic [3:0]  s_pcount_in;
  logic        s_out_valid, s_out_ready, s_out_bit, s_overflow;
  logic [4:0]  s_out_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  xnor_popcount_threshold dut (
    .clk(clk), .rst(rst), .en(en),
    .thr_load(thr_load), .thr_in(thr_in), .thr_invert(thr_invert),
    .in_valid(in_valid), .in_ready(in_ready),
    .pcount_in(pcount_in), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_count(out_count), .overflow(overflow)
  );

  xnor_popcount_threshold #(.ACC_WIDTH(5)) sat_dut (
    .clk(clk), .rst(s_rst), .en(s_en),
    .thr_load(s_thr_load), .thr_in(s_thr_in),
    .thr_invert(s_thr_invert),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .pcount_in(s_pcount_in), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_bit(s_out_bit), .out_count(s_out_count),
    .overflow(s_overflow)
  );

  task automatic send(input logic [3:0] p, input logic last,
                      input logic ld, input logic [11:0] t,
                      input logic iv);
    @(negedge clk);
    in_valid   = 1'b1;
    pcount_in  = p;
    in_last    = last;
    thr_load   = ld;
    thr_in     = t;
    thr_invert = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    thr_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_thr(input logic [11:0] t, input logic iv);
    @(negedge clk);
    in_valid   = 1'b0;
    thr_load   = 1'b1;
    thr_in     = t;
    thr_invert = iv;
    @(posedge clk);
    #1;
    thr_load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_count !== 12'd0 ||
        overflow !== 1'b0)
      $display("FAIL reset_outputs: got v=%b b=%b c=%0d o=%b want 0 0 0 0",
               out_valid, out_bit, out_count, overflow);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0)
      $display("FAIL ready_en_low: got %b want 0", in_ready);
    else passed++;
    en = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_accumulate();
    load_thr(12'd20, 1'b0);
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd3, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 12'd21 || out_bit !== 1'b1)
      $display("FAIL pixel_21: got v=%b c=%0d b=%b want 1 21 1",
               out_valid, out_count, out_bit);
    else passed++;
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL drain_clears_valid: got %b want 0", out_valid);
    else passed++;
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd1, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 12'd19 || out_bit !== 1'b0)
      $display("FAIL pixel_19: got v=%b c=%0d b=%b want 1 19 0",
               out_valid, out_count, out_bit);
    else passed++;
    idle();
  endtask

  task automatic test_back_to_back();
    load_thr(12'd5, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(4'd5, 1'b1, 1'b0, 12'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_count !== 12'd5 || out_bit !== 1'b1 ||
          in_ready !== 1'b1)
        $display("FAIL single_beat_%0d: got v=%b c=%0d b=%b r=%b want 1 5 1 1",
                 i, out_valid, out_count, out_bit, in_ready);
      else passed++;
    end
    idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd7, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 12'd7 || out_bit !== 1'b1)
      $display("FAIL held_result: got v=%b c=%0d b=%b want 1 7 1",
               out_valid, out_count, out_bit);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      send(4'd2, 1'b1, 1'b0, 12'd0, 1'b0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_count !== 12'd7 || out_bit !== 1'b1)
        $display("FAIL stall_%0d: got r=%b v=%b c=%0d b=%b want 0 1 7 1",
                 i, in_ready, out_valid, out_count, out_bit);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_count !== 12'd2 || out_bit !== 1'b0)
      $display("FAIL replace_on_drain: got v=%b c=%0d b=%b want 1 2 0",
               out_valid, out_count, out_bit);
    else passed++;
    idle();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL drain_idle: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_threshold();
    load_thr(12'd15, 1'b0);
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd3, 1'b1, 1'b1, 12'd10, 1'b0);
    checks++;
    if (out_count !== 12'd12 || out_bit !== 1'b0)
      $display("FAIL thr_old_value: got c=%0d b=%b want 12 0",
               out_count, out_bit);
    else passed++;
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd3, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_count !== 12'd12 || out_bit !== 1'b1)
      $display("FAIL thr_new_value: got c=%0d b=%b want 12 1",
               out_count, out_bit);
    else passed++;
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd3, 1'b1, 1'b1, 12'd10, 1'b1);
    checks++;
    if (out_bit !== 1'b1)
      $display("FAIL inv_old_value: got b=%b want 1", out_bit);
    else passed++;
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd3, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_count !== 12'd12 || out_bit !== 1'b0)
      $display("FAIL inv_new_value: got c=%0d b=%b want 12 0",
               out_count, out_bit);
    else passed++;
    idle();
  endtask

  task automatic test_reset_mid_pixel();
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    send(4'd9, 1'b0, 1'b0, 12'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_mid_valid: got %b want 0", out_valid);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    idle();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_mid_no_output: got %b want 0", out_valid);
    else passed++;
    send(4'd4, 1'b1, 1'b0, 12'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 12'd4 || out_bit !== 1'b1)
      $display("FAIL after_reset_pixel: got v=%b c=%0d b=%b want 1 4 1",
               out_valid, out_count, out_bit);
    else passed++;
    idle();
  endtask

  task automatic s_send(input logic [3:0] p, input logic last);
    @(negedge clk);
    s_in_valid  = 1'b1;
    s_pcount_in = p;
    s_in_last   = last;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    s_rst = 1'b0;
    #1;
    checks++;
    if (s_overflow !== 1'b0)
      $display("FAIL sat_reset_overflow: got %b want 0", s_overflow);
    else passed++;
    s_send(4'd9, 1'b0);
    s_send(4'd9, 1'b0);
    s_send(4'd9, 1'b0);
    checks++;
    if (s_overflow !== 1'b0)
      $display("FAIL sat_early_overflow: got %b want 0", s_overflow);
    else passed++;
    s_send(4'd9, 1'b1);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_count !== 5'd31 || s_overflow !== 1'b1)
      $display("FAIL sat_clamp: got v=%b c=%0d o=%b want 1 31 1",
               s_out_valid, s_out_count, s_overflow);
    else passed++;
    s_send(4'd4, 1'b1);
    checks++;
    if (s_out_count !== 5'd4 || s_overflow !== 1'b1)
      $display("FAIL sat_sticky: got c=%0d o=%b want 4 1",
               s_out_count, s_overflow);
    else passed++;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_overflow !== 1'b0)
      $display("FAIL sat_clear_on_reset: got %b want 0", s_overflow);
    else passed++;
    s_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; thr_load = 1'b0; thr_in = '0;
    thr_invert = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    pcount_in = '0; out_ready = 1'b1;
    s_rst = 1'b1; s_en = 1'b1; s_thr_load = 1'b0; s_thr_in = '0;
    s_thr_invert = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
    s_pcount_in = '0; s_out_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_back_to_back();
    test_backpressure();
    test_threshold();
    test_reset_mid_pixel();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/xnor_popcount_threshold.md
# xnor_popcount_threshold

Downstream stage of the 3x3 XNOR convolution PE array. Accumulates the per-window partial popcounts (`pcountout`, ≤9 per beat) across all input channels of one output pixel. Applies the folded batch-norm/sign threshold and emits one binary activation per pixel over a valid/ready handshake, together with the raw count for debug and next-layer buffering.

## Interface
Parameters:
- `PSUM_WIDTH`, 4, width of one incoming partial popcount (3x3 kernel → max 9 < 2^4−1)
- `ACC_WIDTH`, 12, width of per-pixel accumulator, threshold and count output

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  global stage enable; low freezes all state
- `thr_load`  in  1  load `thr_in`/`thr_invert` into threshold registers
- `thr_in`  in  ACC_WIDTH  unsigned popcount threshold
- `thr_invert`  in  1  invert comparison result (negative BN gamma)
- `in_valid`  in  1  `pcount_in` beat valid
- `in_ready`  out  1  stage accepts a beat this cycle
- `pcount_in`  in  PSUM_WIDTH  partial popcount from PE array
- `in_last`  in  1  beat is the last channel of current pixel
- `out_valid`  out  1  result held for consumer
- `out_ready`  in  1  consumer takes result
- `out_bit`  out  1  binary activation
- `out_count`  out  ACC_WIDTH  final (possibly saturated) popcount of pixel
- `overflow`  out  1  sticky: accumulator saturated since reset

## Operation
- Beat accepted ("fire") when `en && in_valid && in_ready`.
- `in_ready = en && (!out_valid || out_ready)`: the stage accepts a beat in the same cycle the held result drains.
- State machine, 2 states:
  - IDLE: acc = 0. A fire without `in_last` → ACCUM. A fire with `in_last` is a single-beat pixel: it emits a result and stays in IDLE.
  - ACCUM: a fire without `in_last` does acc += pcount_in. A fire with `in_last` emits a result, clears acc to 0 and → IDLE.
- Emit on a last beat:
  - sum = acc + zero-extended `pcount_in`.
  - If sum > 2^ACC_WIDTH−1, then sum = 2^ACC_WIDTH−1 and `overflow` ← 1 (sticky).
  - `out_count` ← sum, `out_bit` ← (sum ≥ thr) XOR invert, `out_valid` ← 1.
- Non-last beats saturate identically and also set `overflow`.
- `out_valid` clears when `en && out_ready` and no new emit occurs in the same cycle. Emit and drain in the same cycle: the new result replaces the old one and `out_valid` stays 1.
- `out_bit`/`out_count` are stable while `out_valid && !out_ready`.
- Threshold load:
  - `thr_load` (qualified by `en`) registers `thr_in` and `thr_invert`.
  - An emit in the same cycle as a load compares against the OLD values; the new values apply from the next cycle.
  - A load mid-pixel is legal.
- `en` low: no fire, no drain, no load. All registers hold and `in_ready` = 0.

## Timing
- Reset values (rst sampled high at an edge): acc 0, state IDLE, threshold 0, invert 0, `out_valid` 0, `out_bit` 0, `out_count` 0, `overflow` 0. `in_ready` is combinational and equals `en` after reset.
- Reset mid-pixel discards the partial acc and any held result; no output is produced for that pixel.
- Latency: result visible (`out_valid`=1) on the cycle after the last beat fires.
- Throughput: one beat per cycle sustained, including back-to-back single-beat pixels when `out_ready` is held high.
- Backpressure: with `out_ready` low and `out_valid` high, `in_ready` = 0 and no beat is lost.
- Compare is unsigned, ACC_WIDTH bits. `pcount_in` is zero-extended. No signed arithmetic.

## Structure
- Shared package `bnn_pkg`: default `PSUM_WIDTH`/`ACC_WIDTH` constants and the state enumeration (IDLE, ACCUM). The PE array uses the same PSUM_WIDTH constant.
- One sub-module, `sat_accumulate`: ACC_WIDTH-bit saturating adder. Combinational sum plus saturate flag, used for both the last-beat path and the non-last-beat path.
- Threshold register, output register and FSM stay in the top module.

## Test plan
- Reset, thr=20, invert=0; beats 9,9,3(last) → `out_valid` next cycle, `out_count`=21, `out_bit`=1; beats 9,9,1(last) → count 19, bit 0.
- Single-beat pixels: `pcount_in`=5 with `in_last` every cycle, thr=5, `out_ready`=1 → one result per cycle, each count 5, bit 1, `in_ready` never drops.
- Backpressure: result held with `out_ready`=0 for 4 cycles → `in_ready`=0 and outputs stable. When `out_ready` rises together with a last beat, the new result replaces the old one with no gap.
- Threshold timing: thr_load thr=10 in the same cycle as a last beat summing to 12, old thr=15 → bit 0. The next pixel summing to 12 → bit 1. Repeat with invert=1 → bit inverted.
- Saturation with ACC_WIDTH=5: beats 9,9,9,9(last) → `out_count`=31, `overflow`=1. `overflow` stays 1 for later non-saturating pixels until rst.
- Reset mid-pixel after beats 9,9 → no output. The next pixel 4(last) gives `out_count`=4.
